// File: rtl/fifo_rx.sv
// fifo_rx: receive-side byte assembler.
// Collects bytes from the UART receiver into a block of 2**ADDR_SPACE_EXP
// words for the decrypt datapath. The first byte lands in word 0 (bits [7:0]).
// Once the block is complete it is held until read_block releases it.
// Block state is implied by count: EMPTY (0), FILLING (1..WORDS-1), FULL (WORDS).
module fifo_rx #(
    parameter int DATA_SIZE      = 8,
    parameter int ADDR_SPACE_EXP = 4
) (
    input  logic                                         clk_100MHz,
    input  logic                                         reset_n,
    input  logic [DATA_SIZE-1:0]                         rx_data_in,
    input  logic                                         rx_data_valid,
    input  logic                                         read_block,
    input  logic                                         flush,
    output logic [DATA_SIZE*(2**ADDR_SPACE_EXP)-1:0]     block_data_out,
    output logic [ADDR_SPACE_EXP:0]                      count,
    output logic                                         full,
    output logic                                         empty,
    output logic                                         overflow
);

    localparam int WORDS = 2**ADDR_SPACE_EXP;
    localparam logic [ADDR_SPACE_EXP:0]   COUNT_LAST = (ADDR_SPACE_EXP+1)'(WORDS-1);
    localparam logic [ADDR_SPACE_EXP:0]   COUNT_ONE  = (ADDR_SPACE_EXP+1)'(1);
    localparam logic [ADDR_SPACE_EXP-1:0] ADDR_ONE   = ADDR_SPACE_EXP'(1);

    logic [DATA_SIZE-1:0]      memory [WORDS];
    logic [ADDR_SPACE_EXP-1:0] wr_addr;
    logic [ADDR_SPACE_EXP-1:0] store_addr;
    logic                      release_blk;
    logic                      store_byte;
    logic                      drop_byte;

    // Decode this cycle's action; flush overrides everything else.
    // A release and a write in the same cycle restart the block at word 0.
    always_comb begin
        release_blk = !flush && full && read_block;
        store_byte  = !flush && rx_data_valid && (!full || read_block);
        drop_byte   = !flush && rx_data_valid && full && !read_block;
        store_addr  = release_blk ? '0 : wr_addr;
    end

    // Pointer, occupancy and status flags.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr  <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_addr  <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else if (release_blk) begin
            full <= 1'b0;
            if (store_byte) begin
                wr_addr <= ADDR_ONE;
                count   <= COUNT_ONE;
                empty   <= 1'b0;
            end else begin
                wr_addr <= '0;
                count   <= '0;
                empty   <= 1'b1;
            end
        end else if (store_byte) begin
            // wr_addr wraps to 0 naturally on the last word
            wr_addr <= wr_addr + ADDR_ONE;
            count   <= count + COUNT_ONE;
            empty   <= 1'b0;
            full    <= (count == COUNT_LAST);
        end else if (drop_byte) begin
            overflow <= 1'b1;
        end
    end

    // Word storage; only reset clears it, so a released block stays visible
    // until it is overwritten word by word.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WORDS; i++) begin
                memory[i] <= '0;
            end
        end else if (store_byte) begin
            memory[store_addr] <= rx_data_in;
        end
    end

    // Flatten storage onto the block output, word i at bits [8i+7:8i].
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_pack
        assign block_data_out[gi*DATA_SIZE +: DATA_SIZE] = memory[gi];
    end

endmodule

// File: doc/fifo_rx.md
# fifo_rx

Receive-side byte assembler, the counterpart of the transmit FIFO. It accepts ASCII/ciphertext bytes one at a time from the UART receiver and packs them into a 128-bit block (16 × 8-bit) for the SIMON decrypt datapath. Once 16 bytes have arrived it reports full and holds the block until the consumer acknowledges it. Byte ordering matches the transmit side: the first byte received lands in bits [7:0].

## Interface
- DATA_SIZE, 8, bits per data word
- ADDR_SPACE_EXP, 4, log2 of words per block (16 words, 128-bit block)

- clk_100MHz  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous, active-low reset
- rx_data_in  in  DATA_SIZE  byte from UART receiver, valid only with rx_data_valid
- rx_data_valid  in  1  single-cycle strobe, byte present on rx_data_in
- read_block  in  1  consumer acknowledge; releases a full block
- flush  in  1  synchronous discard of partial or full block
- block_data_out  out  DATA_SIZE*2^ADDR_SPACE_EXP  assembled block, word i at bits [8i+7:8i]
- count  out  ADDR_SPACE_EXP+1  words currently held (0..16)
- full  out  1  16 words held, block_data_out valid
- empty  out  1  no words held
- overflow  out  1  sticky: a byte was dropped while full

## Operation
- Storage: 16 registers of DATA_SIZE bits; write pointer wr_addr (ADDR_SPACE_EXP bits); count one bit wider.
- Byte write (rx_data_valid=1, full=0): memory[wr_addr] <= rx_data_in; wr_addr +1; count +1.
- 16th byte (count=15 and write): count -> 16, wr_addr wraps to 0, full -> 1, empty stays 0.
- Write while full, no read_block: byte dropped, memory unchanged, overflow -> 1.
- read_block while full: count -> 0, full -> 0, empty -> 1, wr_addr -> 0. Memory is not cleared; block_data_out keeps the old contents until overwritten word by word.
- read_block while not full: ignored (no effect on any state).
- read_block and rx_data_valid in the same cycle while full: release happens, and the new byte is stored at word 0. Result: count=1, empty=0, full=0, overflow unchanged.
- flush: count -> 0, wr_addr -> 0, full -> 0, empty -> 1, overflow -> 0. Flush has priority over read_block and rx_data_valid in the same cycle, and that cycle's byte is discarded.
- overflow clears only on reset_n low or flush.
- empty = (count==0); full = (count==16). Both are registered, and they are never both 1.
- States are implicit in count: EMPTY (0), FILLING (1..15), FULL (16).

## Timing
- Reset (reset_n low, asynchronous): all memory words 0, so block_data_out = 0. Also count=0, wr_addr=0, empty=1, full=0, overflow=0.
- Release of reset is synchronous to clk_100MHz. The first byte can be accepted on the first rising edge with reset_n high.
- All inputs are sampled on the rising edge of clk_100MHz. Outputs update on the same edge (1-cycle latency from strobe to count/full/block_data_out).
- full asserts on the edge that samples the 16th rx_data_valid.
- Back-to-back strobes, one per cycle, are supported. There is no minimum gap.
- rx_data_in is don't-care when rx_data_valid=0.
- Reset asserted mid-block: all partial data is lost immediately, without waiting for a clock edge.

## Test plan
- Reset: hold reset_n low with clk running -> block_data_out=0, count=0, empty=1, full=0, overflow=0. Release, then idle 5 cycles -> unchanged.
- Fill: strobe bytes 0x00..0x0F back-to-back ->
  - after edge 1: count=1, empty=0
  - after edge 16: full=1, count=16, block_data_out=0x0F0E0D0C0B0A09080706050403020100
- Overflow: from full, strobe 0xAA -> overflow=1, block unchanged, count=16. Then read_block -> empty=1, full=0, overflow still 1.
- Simultaneous release and write: from full, assert read_block together with rx_data_valid (0x55) -> count=1, full=0, empty=0, bits [7:0]=0x55, bits [127:8] unchanged.
- Flush mid-block: write 5 bytes, then flush together with rx_data_valid (0x77) -> count=0, empty=1, overflow=0, 0x77 not stored. The next 16 bytes fill from word 0.
- Async reset mid-block: after 9 bytes, pulse reset_n low for half a clock period between edges -> outputs go to reset values before the next edge.
